cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multicycle control sequencer for the 16-bit MIPS-style CPU datapath. It latches the 3-bit opcode of the fetched instruction and steps the datapath through fetch, decode, execute, memory and writeback. It drives every datapath control input and gates PC and register-file updates to single-cycle strobes. It also handshakes with instruction and data memory using ready signals, so memory may insert wait states.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles on one memory request; only used with `SEQUENCER_TIMEOUT_EN`.
- `clk` input 1: clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 16: current instruction. Opcode is `instr[15:13]`; R-type funct is `instr[2:0]`.
- `zero` input 1: ALU zero flag from the datapath.
- `imem_ready` input 1: instruction memory has data valid this cycle.
- `dmem_ready` input 1: data memory has completed the read or write this cycle.
- `instr_req` output 1: request an instruction fetch at the current PC.
- `ir_en` output 1: load the instruction register; one-cycle strobe.
- `pc_en` output 1: PC register load enable; one-cycle strobe.
- `memtoreg`, `pcsrc`, `alusrc`, `regdst`, `regwrite`, `jump` output 1 each: datapath controls.
- `alucontrol` output 3: ALU operation select.
- `memread`, `memwrite` output 1 each: data memory request.
- `halted` output 1: the core has stopped on HALT.
- `fault` output 1: a memory timeout occurred. Tied to 0 when the macro is not defined.
- `retired` output 16: count of completed instructions.

## Operation
- Opcodes and their ALU settings:
  - 000 R-type: `alucontrol` = funct.
  - 001 ADDI: `alusrc`=1, `alucontrol`=010.
  - 010 LW: `alusrc`=1, `alucontrol`=010, `memtoreg`=1.
  - 011 SW: `alusrc`=1, `alucontrol`=010.
  - 100 BEQ: `alucontrol`=110.
  - 101 J.
  - 110 NOP.
  - 111 HALT.
- `regdst`=1 for R-type only.
- States are FETCH, DECODE, EXEC, MEM, WB, HALT, and FAULT (FAULT exists only with the macro).
- FETCH:
  - `instr_req`=1 until `imem_ready`.
  - On `imem_ready`: `ir_en`=1 for one cycle, then go to DECODE.
- DECODE: latch `instr[15:13]` and `instr[2:0]` internally, then go to EXEC.
- EXEC, by opcode:
  - R-type and ADDI go to WB.
  - LW and SW go to MEM.
  - BEQ: `pc_en`=1 with `pcsrc`=`zero`, then go to FETCH.
  - J: `pc_en`=1 with `jump`=1, then go to FETCH.
  - NOP: `pc_en`=1, then go to FETCH.
  - HALT: go to HALT.
- MEM:
  - Hold `memread` (LW) or `memwrite` (SW) until `dmem_ready`.
  - On `dmem_ready`, LW goes to WB.
  - On `dmem_ready`, SW asserts `pc_en`=1 and goes to FETCH.
- WB:
  - `regwrite`=1 and `pc_en`=1 for one cycle, then go to FETCH.
  - `regwrite` is asserted only in WB.
- HALT: `halted`=1. The only exit is `reset`.
- Control levels from the latched opcode are held stable from EXEC through the end of the instruction. They are 0 in FETCH and DECODE.
- `retired` increments by 1 in every cycle where `pc_en`=1, wrapping modulo 2^16.
  - HALT does not count.
- Outputs are combinational decodes of the state and latched opcode. They are registered only in the state register and the counters.

## Timing
- Latency with zero wait states (`ready` high on the first request cycle):
  - R-type and ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, J and NOP: 3 cycles.
- Each wait cycle on `imem_ready` or `dmem_ready` adds exactly 1 cycle.
- Reset:
  - While `reset` is high, all outputs are 0.
  - On the edge where `reset` is sampled high, the next state is FETCH, the latched opcode becomes 000, and `retired` becomes 0.
  - On the first cycle after `reset` falls, `instr_req`=1.
- Reset mid-MEM: `memwrite` and `memread` drop in the same cycle `reset` rises. The instruction is not retired.
- A ready input arriving while no request is outstanding is ignored.
- `pc_en` and `regwrite` never last more than one cycle per instruction.

## Configuration
- `SEQUENCER_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH or MEM and increments on each cycle the matching ready is low.
  - When it reaches `TIMEOUT`, the sequencer enters FAULT. There `fault`=1 and every other output is 0 until `reset`.
- `SEQUENCER_TIMEOUT_EN` not defined: there is no counter and no FAULT state, `fault` is tied to 0, and waits are unbounded.

## Test plan
- ADD (0x0000-format R-type, funct 010), ready always high:
  - `ir_en` pulses in cycle 1.
  - `regdst`=1 and `alucontrol`=010 in cycles 3-4.
  - `regwrite` and `pc_en` pulse together in cycle 4.
  - `retired` becomes 1.
- LW with `dmem_ready` held low for 3 cycles:
  - `memread` stays high for 4 cycles.
  - `memtoreg`=1 through WB.
  - Total 8 cycles, with a single `regwrite` pulse.
- BEQ with `zero`=1, then with `zero`=0: `pc_en` in cycle 3 with `pcsrc`=1, then with `pcsrc`=0. `regwrite` is never asserted.
- J followed by HALT:
  - `jump`=1 with `pc_en` in cycle 3.
  - The HALT instruction makes `halted`=1 from cycle 6 onward and `retired` stays at 1.
  - Asserting `reset` for one cycle clears `halted` and `retired`, then `instr_req`=1.
- SW with `reset` raised during MEM: `memwrite` is 0 in the reset cycle, the state returns to FETCH, and `retired` is 0.
- With `SEQUENCER_TIMEOUT_EN` and `TIMEOUT`=4, holding `imem_ready` low: `fault`=1 after 4 wait cycles, and `instr_req`=0 thereafter until `reset`.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control FSM for the 16-bit MIPS-style datapath; SEQUENCER_TIMEOUT_EN adds a memory wait timeout and FAULT state
module cpu_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        instr_req,
    output logic        ir_en,
    output logic        pc_en,
    output logic        memtoreg,
    output logic        pcsrc,
    output logic        alusrc,
    output logic        regdst,
    output logic        regwrite,
    output logic        jump,
    output logic [2:0]  alucontrol,
    output logic        memread,
    output logic        memwrite,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);
    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
`ifdef SEQUENCER_TIMEOUT_EN
        HALT,
        FAULT
`else
        HALT
`endif
    } state_t;

    state_t      state, next;
    logic [2:0]  op, fn;
    logic [15:0] cnt;
    logic        ctl, is_r, is_imm, is_lw, is_sw, is_beq, is_j, is_nop, is_halt;
    logic        unused_bits;

    assign unused_bits = ^{instr[12:3], 1'(TIMEOUT)};

    assign is_r    = op == 3'd0;
    assign is_imm  = op == 3'd1;
    assign is_lw   = op == 3'd2;
    assign is_sw   = op == 3'd3;
    assign is_beq  = op == 3'd4;
    assign is_j    = op == 3'd5;
    assign is_nop  = op == 3'd6;
    assign is_halt = op == 3'd7;

`ifdef SEQUENCER_TIMEOUT_EN
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] wcnt;
    logic         waiting, expired;
    assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
    assign expired = waiting && wcnt == LAST;
    always_ff @(posedge clk) begin
        wcnt <= (reset || !waiting) ? '0 : wcnt + 1'b1;
    end
    assign fault = !reset && state == FAULT;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            FETCH:   next = imem_ready ? DECODE : FETCH;
            DECODE:  next = EXEC;
            EXEC:    next = (is_r || is_imm) ? WB : (is_lw || is_sw) ? MEM : is_halt ? HALT : FETCH;
            MEM:     next = !dmem_ready ? MEM : is_lw ? WB : FETCH;
            WB:      next = FETCH;
            default: next = state;
        endcase
`ifdef SEQUENCER_TIMEOUT_EN
        if (expired) next = FAULT;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            op    <= 3'd0;
            fn    <= 3'd0;
            cnt   <= 16'd0;
        end else begin
            state <= next;
            if (state == DECODE) begin
                op <= instr[15:13];
                fn <= instr[2:0];
            end
            if (pc_en) cnt <= cnt + 16'd1;
        end
    end

    // control levels follow the latched opcode from EXEC to the end of the instruction
    assign ctl        = !reset && (state == EXEC || state == MEM || state == WB);
    assign instr_req  = !reset && state == FETCH;
    assign ir_en      = instr_req && imem_ready;
    assign alusrc     = ctl && (is_imm || is_lw || is_sw);
    assign alucontrol = !ctl ? 3'b000 : is_r ? fn : (is_imm || is_lw || is_sw) ? 3'b010 : is_beq ? 3'b110 : 3'b000;
    assign memtoreg   = ctl && is_lw;
    assign regdst     = ctl && is_r;
    assign jump       = ctl && is_j;
    assign pcsrc      = ctl && is_beq && zero;
    assign memread    = ctl && state == MEM && is_lw;
    assign memwrite   = ctl && state == MEM && is_sw;
    assign regwrite   = ctl && state == WB;
    assign pc_en      = regwrite || (ctl && state == EXEC && (is_beq || is_j || is_nop)) || (memwrite && dmem_ready);
    assign halted     = !reset && (state == HALT || (state == EXEC && is_halt));
    assign retired    = reset ? 16'd0 : cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: randomized instruction stream checked against a per-instruction cycle-count model
`timescale 1ns/1ps
module tb_cpu_sequencer;
  logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [15:0] instr = 16'd0;
  logic        instr_req, ir_en, pc_en, memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
  logic        memread, memwrite, halted, fault;
  logic [2:0]  alucontrol;
  logic [15:0] retired;
  logic [15:0] model_retired = 16'd0;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  cpu_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .instr_req(instr_req), .ir_en(ir_en), .pc_en(pc_en),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .alusrc(alusrc), .regdst(regdst),
    .regwrite(regwrite), .jump(jump), .alucontrol(alucontrol),
    .memread(memread), .memwrite(memwrite), .halted(halted), .fault(fault),
    .retired(retired)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] alu_of(input logic [2:0] op, input logic [2:0] fn);
    return op == 3'd0 ? fn : (op >= 3'd1 && op <= 3'd3) ? 3'b010 : op == 3'd4 ? 3'b110 : 3'b000;
  endfunction
  task automatic run_instr(input logic [2:0] op, input logic [2:0] fn, input int iw, input int dw, input int stop);
    int         n, last, m;
    logic       mem, ex, exp_pc, exp_pcsrc;
    logic [2:0] exp_alu;
    logic [9:0] mid;
    mem = op == 3'd2 || op == 3'd3;
    n = op == 3'd7 ? iw + 6 : (op <= 3'd1 || op == 3'd3) ? iw + 4 : op == 3'd2 ? iw + 5 : iw + 3;
    if (mem) n += dw;
    last = stop > 0 ? stop : n;
    mid = 10'($urandom);
    instr = {op, mid, fn};
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      reset = 1'b0;
      m = k - iw - 3;
      imem_ready = k <= iw ? 1'b0 : k == iw + 1 ? 1'b1 : 1'($urandom);
      dmem_ready = (mem && m >= 1 && m <= dw) ? 1'b0 : (mem && m == dw + 1) ? 1'b1 : 1'($urandom);
      zero = 1'($urandom);
      #1;
      ex = k >= iw + 3;
      exp_pc = k == n && op != 3'd7;
      exp_alu = ex ? alu_of(op, fn) : 3'b000;
      exp_pcsrc = (k == iw + 3 && op == 3'd4) ? zero : 1'b0;
      chk("instr_req", instr_req, k <= iw + 1);
      chk("ir_en", ir_en, k == iw + 1);
      chk("alusrc", alusrc, ex && op >= 3'd1 && op <= 3'd3);
      chk("alucontrol", alucontrol, exp_alu);
      chk("memtoreg", memtoreg, ex && op == 3'd2);
      chk("regdst", regdst, ex && op == 3'd0);
      chk("jump", jump, ex && op == 3'd5);
      chk("pcsrc", pcsrc, exp_pcsrc);
      chk("memread", memread, op == 3'd2 && m >= 1 && m <= dw + 1);
      chk("memwrite", memwrite, op == 3'd3 && m >= 1 && m <= dw + 1);
      chk("regwrite", regwrite, k == n && op <= 3'd2);
      chk("pc_en", pc_en, exp_pc);
      chk("halted", halted, op == 3'd7 && k >= iw + 3);
      chk("fault", fault, 1'b0);
      chk("retired", retired, model_retired);
      if (exp_pc) model_retired++;
    end
  endtask
  task automatic do_reset();
    logic [31:0] all_o;
    @(negedge clk);
    reset = 1'b1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    zero = 1'($urandom);
    #1;
    all_o = {instr_req, ir_en, pc_en, memtoreg, pcsrc, alusrc, regdst, regwrite, jump,
             alucontrol, memread, memwrite, halted, fault, retired};
    chk("rst_memwrite", memwrite, 1'b0);
    chk("rst_all_outputs", all_o, 32'd0);
    model_retired = 16'd0;
  endtask
`ifdef SEQUENCER_TIMEOUT_EN
  task automatic run_timeout();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      reset = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'($urandom);
      #1;
      chk("to_fault", fault, k > 4);
      chk("to_instr_req", instr_req, k <= 4);
    end
  endtask
`endif
  initial begin
    do_reset();
    run_instr(3'd0, 3'b010, 0, 0, 0);
    run_instr(3'd2, 3'($urandom), 0, 3, 0);
    run_instr(3'd4, 3'($urandom), 0, 0, 0);
    run_instr(3'd4, 3'($urandom), 1, 0, 0);
    run_instr(3'd3, 3'($urandom), 1, 2, 0);
    run_instr(3'd1, 3'($urandom), 2, 0, 0);
    for (int i = 0; i < 40; i++)
      run_instr(3'($urandom_range(6, 0)), 3'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), 0);
    do_reset();
    run_instr(3'd5, 3'($urandom), 0, 0, 0);
    run_instr(3'd7, 3'($urandom), 0, 0, 0);
    do_reset();
    run_instr(3'd6, 3'($urandom), 0, 0, 0);
    run_instr(3'd3, 3'($urandom), 0, 2, 4);
    do_reset();
    run_instr(3'd0, 3'($urandom), 1, 0, 0);
`ifdef SEQUENCER_TIMEOUT_EN
    do_reset();
    run_timeout();
    do_reset();
    run_instr(3'd0, 3'($urandom), 0, 0, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
